// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential unsigned multiply/divide unit with HI/LO registers.
// One shift-add (MULTU) or restoring (DIVU) step per clock, WIDTH steps per op.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - one-cycle op request, qualified by aluop
//   aluop     - 6'b010000 DIVU, 6'b010001 MULTU, anything else ignored
//   a, b      - operands (multiplicand/multiplier, dividend/divisor)
//   hi_we     - MTHI strobe (IDLE only, no accepted start)
//   lo_we     - MTLO strobe (IDLE only, no accepted start)
//   wdata     - MTHI/MTLO data
//   busy      - op in flight (MUL, DIV, DONE)
//   stall     - busy | (start & valid aluop), combinational
//   done      - one-cycle completion pulse
//   hi, lo    - HI/LO registers
//   div_zero  - last accepted DIVU had b == 0
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    // state | meaning
    // IDLE  | waiting for start; MTHI/MTLO accepted here
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | result in HI/LO, done pulse, back to IDLE next edge
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] OP_DIVU   = 6'b010000;
    localparam logic [5:0] OP_MULTU  = 6'b010001;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;       // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   opb_q, opb_d;       // divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic             is_mul, is_div, req;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last;

    assign is_mul = start && (aluop == OP_MULTU);
    assign is_div = start && (aluop == OP_DIVU);
    assign req    = is_mul || is_div;

    // Multiplier sits in the low half of acc and is shifted out LSB first while
    // product bits shift in from the top; after WIDTH steps acc is the product.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: a borrow out of the (WIDTH+1)-bit subtract means the
    // shifted remainder is below the divisor. Divisor 0 never borrows, which
    // yields quotient all ones and remainder equal to the dividend.
    assign rem_shift = {rem_q, opa_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_q};
    assign rem_ge    = ~rem_diff[WIDTH];
    assign rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {opa_q[WIDTH-2:0], rem_ge};

    assign last = (cnt_q == LAST_ITER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (is_mul) begin
                    opa_d   = a;
                    opb_d   = b;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_MUL;
                end else if (is_div) begin
                    opa_d   = a;
                    opb_d   = b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dz_d    = (b == '0);
                    state_d = S_DIV;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                opa_d = quo_next;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    hi_d    = rem_next;
                    lo_d    = quo_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign stall    = busy || req;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int W = 32;
    localparam logic [5:0] OP_DIVU  = 6'b010000;
    localparam logic [5:0] OP_MULTU = 6'b010001;
    localparam logic [5:0] OP_BAD   = 6'b000010;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   aluop;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;
    logic         div_zero;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .aluop    (aluop),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    int           t0;
    int           obs_lat;
    logic         obs_stall;
    logic [W-1:0] obs_hi, obs_lo;
    logic         obs_dz, obs_busy_done, obs_busy_after, obs_done_after;
    logic [W-1:0] exp_hi, exp_lo;
    logic         exp_dz;

    task automatic push_model(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        exp_t e;
        if (op == OP_MULTU) begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            e = '{hi: p[2*W-1:W], lo: p[W-1:0], dz: 1'b0};
        end else if (y == '0) begin
            e = '{hi: x, lo: {W{1'b1}}, dz: 1'b1};
        end else begin
            e = '{hi: x % y, lo: x / y, dz: 1'b0};
        end
        sb.push_back(e);
    endtask

    // Presents a request for one cycle, records the accepting edge, then
    // scrambles the operand inputs so later changes on a/b are exercised.
    task automatic drive_start(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        aluop = op;
        a     = x;
        b     = y;
        push_model(op, x, y);
        #1 obs_stall = stall;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        aluop = 6'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done();
        exp_t e;
        obs_lat = -1;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                obs_lat = cyc - t0;
                break;
            end
        end
        obs_hi        = hi;
        obs_lo        = lo;
        obs_dz        = div_zero;
        obs_busy_done = busy;
        @(posedge clk);
        #1;
        obs_busy_after = busy;
        obs_done_after = done;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{hi: 'x, lo: 'x, dz: 1'bx};
        exp_hi = e.hi;
        exp_lo = e.lo;
        exp_dz = e.dz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        aluop = 6'd0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #3;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL reset stall: got %b want 0", stall); end
        n_cmp++; if (hi !== '0)         begin n_bad++; $display("FAIL reset hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0)         begin n_bad++; $display("FAIL reset lo: got %h want 0", lo); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset div_zero: got %b want 0", div_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_max();
        drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++; if (obs_stall !== 1'b1) begin n_bad++; $display("FAIL mul_max stall: got %b want 1", obs_stall); end
        wait_done();
        n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL mul_max latency: got %0d want %0d", obs_lat, W); end
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL mul_max hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL mul_max lo: got %h want %h", obs_lo, exp_lo); end
        n_cmp++; if (obs_busy_done !== 1'b1) begin n_bad++; $display("FAIL mul_max busy_in_done: got %b want 1", obs_busy_done); end
        n_cmp++; if (obs_busy_after !== 1'b0) begin n_bad++; $display("FAIL mul_max busy_after: got %b want 0", obs_busy_after); end
        n_cmp++; if (obs_done_after !== 1'b0) begin n_bad++; $display("FAIL mul_max done_width: got %b want 0", obs_done_after); end
    endtask

    task automatic test_div_basic();
        drive_start(OP_DIVU, 32'd100, 32'd7);
        wait_done();
        n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL div_basic latency: got %0d want %0d", obs_lat, W); end
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL div_basic hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL div_basic lo: got %h want %h", obs_lo, exp_lo); end
        n_cmp++; if (obs_dz !== exp_dz) begin n_bad++; $display("FAIL div_basic div_zero: got %b want %b", obs_dz, exp_dz); end
        drive_start(OP_MULTU, 32'd3, 32'd5);
        wait_done();
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL mul_3x5 hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL mul_3x5 lo: got %h want %h", obs_lo, exp_lo); end
    endtask

    task automatic test_div_zero();
        drive_start(OP_DIVU, 32'd5, 32'd0);
        wait_done();
        n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL div_zero latency: got %0d want %0d", obs_lat, W); end
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL div_zero hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL div_zero lo: got %h want %h", obs_lo, exp_lo); end
        n_cmp++; if (obs_dz !== exp_dz) begin n_bad++; $display("FAIL div_zero flag: got %b want %b", obs_dz, exp_dz); end
        @(negedge clk);
        start = 1'b1;
        aluop = OP_BAD;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (div_zero !== 1'b1) begin n_bad++; $display("FAIL div_zero hold: got %b want 1", div_zero); end
    endtask

    task automatic test_reset_mid();
        drive_start(OP_MULTU, 32'h0123_4567, 32'h89AB_CDEF);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        n_cmp++; if (hi !== '0)         begin n_bad++; $display("FAIL reset_mid hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0)         begin n_bad++; $display("FAIL reset_mid lo: got %h want 0", lo); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_mid div_zero: got %b want 0", div_zero); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(OP_DIVU, 32'd9, 32'd3);
        wait_done();
        n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL after_reset latency: got %0d want %0d", obs_lat, W); end
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL after_reset hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL after_reset lo: got %h want %h", obs_lo, exp_lo); end
    endtask

    task automatic test_mthi_invalid();
        logic [W-1:0] lo_before;
        lo_before = lo;
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        n_cmp++; if (hi !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi hi: got %h want 00001234", hi); end
        n_cmp++; if (lo !== lo_before) begin n_bad++; $display("FAIL mthi lo_untouched: got %h want %h", lo, lo_before); end
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_55AA;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        n_cmp++; if (hi !== 32'h0000_55AA) begin n_bad++; $display("FAIL mthlo hi: got %h want 000055aa", hi); end
        n_cmp++; if (lo !== 32'h0000_55AA) begin n_bad++; $display("FAIL mthlo lo: got %h want 000055aa", lo); end
        start = 1'b1;
        aluop = OP_BAD;
        a     = 32'd7;
        b     = 32'd9;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL bad_op stall: got %b want 0", stall); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_op busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0000_55AA || lo !== 32'h0000_55AA) begin
            n_bad++; $display("FAIL bad_op hilo: got %h/%h want 000055aa/000055aa", hi, lo);
        end
        // MTHI/MTLO in the same cycle as an accepted start are dropped.
        start = 1'b1;
        aluop = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_ABCD;
        push_model(OP_MULTU, 32'd6, 32'd7);
        @(posedge clk);
        #1 t0 = cyc;
        n_cmp++; if (hi !== 32'h0000_55AA) begin n_bad++; $display("FAIL mthi_with_start hi: got %h want 000055aa", hi); end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done();
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL mul_6x7 lo: got %h want %h", obs_lo, exp_lo); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] hi_before;
        drive_start(OP_DIVU, 32'd100, 32'd7);
        hi_before = hi;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        aluop = OP_MULTU;
        a     = 32'd2;
        b     = 32'd2;
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b stall: got %b want 1", stall); end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        n_cmp++; if (hi !== hi_before) begin n_bad++; $display("FAIL b2b hi_busy_write: got %h want %h", hi, hi_before); end
        wait_done();
        n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL b2b latency: got %0d want %0d", obs_lat, W); end
        n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL b2b hi: got %h want %h", obs_hi, exp_hi); end
        n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL b2b lo: got %h want %h", obs_lo, exp_lo); end
        n_cmp++; if (obs_busy_after !== 1'b0) begin n_bad++; $display("FAIL b2b restarted: got busy %b want 0", obs_busy_after); end
    endtask

    task automatic test_random();
        logic [5:0]   op;
        logic [W-1:0] x, y;
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MULTU : OP_DIVU;
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = W'($urandom_range(1, 20));
                1:       y = W'($urandom_range(0, 65535));
                default: y = $urandom;
            endcase
            drive_start(op, x, y);
            wait_done();
            n_cmp++; if (obs_lat != W) begin n_bad++; $display("FAIL rand%0d latency: got %0d want %0d", i, obs_lat, W); end
            n_cmp++; if (obs_hi !== exp_hi) begin n_bad++; $display("FAIL rand%0d hi: op %b a %h b %h got %h want %h", i, op, x, y, obs_hi, exp_hi); end
            n_cmp++; if (obs_lo !== exp_lo) begin n_bad++; $display("FAIL rand%0d lo: op %b a %h b %h got %h want %h", i, op, x, y, obs_lo, exp_lo); end
            n_cmp++; if (obs_dz !== exp_dz) begin n_bad++; $display("FAIL rand%0d div_zero: got %b want %b", i, obs_dz, exp_dz); end
        end
    endtask

    initial begin
        test_reset();
        test_mul_max();
        test_div_basic();
        test_div_zero();
        test_reset_mid();
        test_mthi_invalid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
